// File: rtl/bank_timing_pkg.sv
// Shared types and helpers for the per-bank auto-precharge / refresh window tracker.
package bank_timing_pkg;

  typedef enum logic [1:0] {
    RDAP = 2'd0,
    WRAP = 2'd1,
    PRE  = 2'd2,
    REF  = 2'd3
  } apMode_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    COUNTING = 2'd2
  } bankState_t;

  // Counter width able to hold the longest window length.
  function automatic int unsigned cwFor(input int unsigned trp, input int unsigned twr,
                                        input int unsigned trtp, input int unsigned trfc);
    int unsigned m;
    m = trtp + trp;
    if (twr + trp > m) m = twr + trp;
    if (trp > m) m = trp;
    if (trfc > m) m = trfc;
    return $clog2(m + 1);
  endfunction

  // Counter load value (window length minus one) for a given mode.
  function automatic int unsigned loadFor(input apMode_t mode, input int unsigned trp,
                                          input int unsigned twr, input int unsigned trtp,
                                          input int unsigned trfc);
    int unsigned t;
    case (mode)
      RDAP:    t = trtp + trp;
      WRAP:    t = twr + trp;
      PRE:     t = trp;
      default: t = trfc;
    endcase
    return t - 1;
  endfunction

endpackage

// File: rtl/bank_timing_slot.sv
// One bank's window FSM (IDLE -> PENDING -> COUNTING) plus its down-counter.
// BANK_TIMING_ERRCHK_EN adds an assertion that the counter is zero in IDLE.
module bank_timing_slot
  import bank_timing_pkg::*;
#(
  parameter int unsigned tRP  = 16,
  parameter int unsigned tWR  = 18,
  parameter int unsigned tRTP = 8,
  parameter int unsigned tRFC = 260
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    setup_req,
  input  logic    rank_ok,
  input  apMode_t setup_mode,
  input  logic    ack_req,
  input  logic    ack_ref,
  output logic    busy,
  output logic    done,
  output logic    setup_err,
  output logic    ack_match
);

  localparam int unsigned CW = cwFor(tRP, tWR, tRTP, tRFC);

  bankState_t    state;
  bankState_t    state_nxt;
  apMode_t       mode;
  logic [CW-1:0] cnt;
  logic          setup_take;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (setup_take) state_nxt = PENDING;
      PENDING:  if (ack_match) state_nxt = COUNTING;
      COUNTING: if (cnt == '0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output and hit decode against the pre-edge state.
  always_comb begin
    busy       = (state != IDLE);
    setup_take = setup_req && rank_ok && (state == IDLE);
    setup_err  = setup_req && (state != IDLE);
    ack_match  = ack_req && (state == PENDING) && ((mode == REF) == ack_ref);
  end

  // Mode captured at reservation time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            mode <= RDAP;
    else if (setup_take) mode <= setup_mode;
  end

  // Down-counter: loaded on acknowledge, saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (ack_match)
      cnt <= CW'(loadFor(mode, tRP, tWR, tRTP, tRFC));
    else if (state == COUNTING && cnt != '0)
      cnt <= cnt - CW'(1);
  end

  // Done pulse lands on the first cycle back in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) done <= 1'b0;
    else      done <= (state == COUNTING) && (cnt == '0);
  end

`ifdef BANK_TIMING_ERRCHK_EN
  idle_cnt_zero: assert property (@(posedge clk) disable iff (!rst)
                                  !(state == IDLE && cnt != '0));
`endif

endmodule

// File: rtl/bank_timing_tracker.sv
// Multi-rank per-bank timing window tracker (RDAP/WRAP/PRE/REF).
// Decodes setup/acknowledge hits per slot; BANK_TIMING_ERRCHK_EN enables
// setupErr/ackErr generation and slot assertions (otherwise both are tied low).
module bank_timing_tracker
  import bank_timing_pkg::*;
#(
  parameter int unsigned NUMRANK      = 2,
  parameter int unsigned NUMBANK      = 4,
  parameter int unsigned NUMBANKGROUP = 4,
  parameter int unsigned TOTALBANKS   = NUMBANK * NUMBANKGROUP,
  parameter int unsigned tRP          = 16,
  parameter int unsigned tWR          = 18,
  parameter int unsigned tRTP         = 8,
  parameter int unsigned tRFC         = 260
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             setupValid,
  input  logic [1:0]                       setupMode,
  input  logic [$clog2(NUMRANK)-1:0]       setupRank,
  input  logic [$clog2(TOTALBANKS)-1:0]    setupBank,
  input  logic                             ackValid,
  input  logic                             ackRef,
  input  logic [$clog2(NUMRANK)-1:0]       ackRank,
  input  logic [$clog2(TOTALBANKS)-1:0]    ackBank,
  output logic [NUMRANK*TOTALBANKS-1:0]    bankBusy,
  output logic [NUMRANK*TOTALBANKS-1:0]    bankDone,
  output logic                             setupErr,
  output logic                             ackErr
);

  localparam int unsigned NSLOT = NUMRANK * TOTALBANKS;
  localparam int unsigned RW    = $clog2(NUMRANK);
  localparam int unsigned BW    = $clog2(TOTALBANKS);

  apMode_t          setup_mode;
  logic [NSLOT-1:0] setup_req;
  logic [NSLOT-1:0] ack_req;
  logic [NSLOT-1:0] ack_match;
  logic [NSLOT-1:0] setup_err_vec;
  logic [NUMRANK-1:0] rank_idle;
  logic             rank_ok;

  // Per-slot hit decode; REF setup is gated on the whole rank being idle.
  always_comb begin
    setup_mode = apMode_t'(setupMode);
    setup_req  = '0;
    ack_req    = '0;
    rank_idle  = '1;
    for (int unsigned r = 0; r < NUMRANK; r++) begin
      for (int unsigned b = 0; b < TOTALBANKS; b++) begin
        if (bankBusy[r*TOTALBANKS+b]) rank_idle[r] = 1'b0;
        setup_req[r*TOTALBANKS+b] = setupValid && (setupRank == RW'(r)) &&
                                    ((setup_mode == REF) || (setupBank == BW'(b)));
        ack_req[r*TOTALBANKS+b]   = ackValid && (ackRank == RW'(r)) &&
                                    (ackRef || (ackBank == BW'(b)));
      end
    end
    rank_ok = (setup_mode != REF) || rank_idle[setupRank];
  end

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    bank_timing_slot #(
      .tRP  (tRP),
      .tWR  (tWR),
      .tRTP (tRTP),
      .tRFC (tRFC)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .setup_req  (setup_req[i]),
      .rank_ok    (rank_ok),
      .setup_mode (setup_mode),
      .ack_req    (ack_req[i]),
      .ack_ref    (ackRef),
      .busy       (bankBusy[i]),
      .done       (bankDone[i]),
      .setup_err  (setup_err_vec[i]),
      .ack_match  (ack_match[i])
    );
  end

`ifdef BANK_TIMING_ERRCHK_EN
  // Registered error pulses; an acknowledge is illegal when no slot accepts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      setupErr <= 1'b0;
      ackErr   <= 1'b0;
    end else begin
      setupErr <= |setup_err_vec;
      ackErr   <= ackValid && !(|ack_match);
    end
  end
`else
  logic err_unused;

  // Error reporting disabled; illegal events are still ignored by the slots.
  always_comb begin
    setupErr   = 1'b0;
    ackErr     = 1'b0;
    err_unused = ^{setup_err_vec, ack_match};
  end
`endif

endmodule

// File: tb/tb_bank_timing_tracker.sv
// Directed self-checking bench for bank_timing_tracker (default parameters).
module tb_bank_timing_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        setupValid;
  logic [1:0]  setupMode;
  logic        setupRank;
  logic [3:0]  setupBank;
  logic        ackValid;
  logic        ackRef;
  logic        ackRank;
  logic [3:0]  ackBank;
  logic [31:0] bankBusy;
  logic [31:0] bankDone;
  logic        setupErr;
  logic        ackErr;

`ifdef BANK_TIMING_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic        sv;
    logic [1:0]  sm;
    logic        sr;
    logic [3:0]  sb;
    logic        av;
    logic        ar;
    logic        ark;
    logic [3:0]  ab;
    logic        se;
    logic        ae;
    logic [31:0] busy;
    logic [31:0] done;
  } vec_t;

  vec_t tbl[8];

  bank_timing_tracker dut (
    .clk        (clk),
    .rst        (rst),
    .setupValid (setupValid),
    .setupMode  (setupMode),
    .setupRank  (setupRank),
    .setupBank  (setupBank),
    .ackValid   (ackValid),
    .ackRef     (ackRef),
    .ackRank    (ackRank),
    .ackBank    (ackBank),
    .bankBusy   (bankBusy),
    .bankDone   (bankDone),
    .setupErr   (setupErr),
    .ackErr     (ackErr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] busy, input logic [31:0] done,
                         input logic se, input logic ae);
    chk({tag, " busy"}, bankBusy, busy);
    chk({tag, " done"}, bankDone, done);
    chk({tag, " setupErr"}, {31'b0, setupErr}, {31'b0, se & ERRCHK});
    chk({tag, " ackErr"}, {31'b0, ackErr}, {31'b0, ae & ERRCHK});
  endtask

  // Drive one cycle's inputs, let the edge sample them, then return to idle.
  task automatic drive(input logic sv, input logic [1:0] sm, input logic sr, input logic [3:0] sb,
                       input logic av, input logic ar, input logic ark, input logic [3:0] ab);
    setupValid = sv; setupMode = sm; setupRank = sr; setupBank = sb;
    ackValid = av; ackRef = ar; ackRank = ark; ackBank = ab;
    @(posedge clk);
    #1;
    setupValid = 1'b0; ackValid = 1'b0; ackRef = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic idle_check(input int n, input logic [31:0] busy, input logic [31:0] done);
    for (int i = 0; i < n; i++) begin
      idle();
      chk_all("idle", busy, done, 1'b0, 1'b0);
    end
  endtask

  // Idle through the rest of a window; the last cycle must show the done pulse.
  task automatic wait_window(input int n, input logic [31:0] busy, input logic [31:0] done_mask);
    idle_check(n - 1, busy, 32'h0);
    idle();
    chk_all("window end", busy & ~done_mask, done_mask, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] eb;
    logic [31:0] ed;

    setupValid = 1'b0; setupMode = 2'd0; setupRank = 1'b0; setupBank = 4'd0;
    ackValid = 1'b0; ackRef = 1'b0; ackRank = 1'b0; ackBank = 4'd0;
    rst = 1'b0;
    #12;
    chk_all("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // RDAP rank0 bank5: setup at edge 10, ack at edge 14, done after edge 38.
    repeat (9) idle();
    drive(1'b1, 2'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_all("rdap setup", 32'h20, 32'h0, 1'b0, 1'b0);
    idle_check(3, 32'h20, 32'h0);
    drive(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5);
    chk_all("rdap ack", 32'h20, 32'h0, 1'b0, 1'b0);
    wait_window(24, 32'h20, 32'h20);
    idle_check(1, 32'h0, 32'h0);

    // Single-cycle legality vectors on rank0 bank1.
    tbl[0] = '{"ack idle bank",      0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 32'h0, 32'h0};
    tbl[1] = '{"setup+ack same bank", 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 32'h2, 32'h0};
    tbl[2] = '{"setup pending bank",  1, 2, 0, 1, 0, 0, 0, 0, 1, 0, 32'h2, 32'h0};
    tbl[3] = '{"ackRef no ref bank",  0, 0, 0, 0, 1, 1, 0, 3, 0, 1, 32'h2, 32'h0};
    tbl[4] = '{"ref setup blocked",   1, 3, 0, 7, 0, 0, 0, 0, 1, 0, 32'h2, 32'h0};
    tbl[5] = '{"ack pending bank",    0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 32'h2, 32'h0};
    tbl[6] = '{"ack counting bank",   0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 32'h2, 32'h0};
    tbl[7] = '{"quiet",               0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 32'h0};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].sv, tbl[i].sm, tbl[i].sr, tbl[i].sb,
            tbl[i].av, tbl[i].ar, tbl[i].ark, tbl[i].ab);
      chk_all(tbl[i].name, tbl[i].busy, tbl[i].done, tbl[i].se, tbl[i].ae);
    end
    wait_window(22, 32'h2, 32'h2);
    idle_check(1, 32'h0, 32'h0);

    // Overlapping WRAP rank1 bank0 (34 cycles) and PRE rank0 bank3 (16 cycles).
    drive(1'b1, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_all("wrap setup", 32'h0001_0000, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_all("pre setup", 32'h0001_0008, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0);
    chk_all("wrap ack", 32'h0001_0008, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3);
    chk_all("pre ack", 32'h0001_0008, 32'h0, 1'b0, 1'b0);
    for (int k = 4; k <= 37; k++) begin
      idle();
      eb = ((k < 36) ? 32'h0001_0000 : 32'h0) | ((k < 19) ? 32'h8 : 32'h0);
      ed = ((k == 36) ? 32'h0001_0000 : 32'h0) | ((k == 19) ? 32'h8 : 32'h0);
      chk_all($sformatf("overlap k=%0d", k), eb, ed, 1'b0, 1'b0);
    end

    // REF on rank1: blocked by pending bank2, then a full-rank window.
    drive(1'b1, 2'd2, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_all("r1b2 setup", 32'h0004_0000, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_all("ref blocked", 32'h0004_0000, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd2);
    chk_all("r1b2 ack", 32'h0004_0000, 32'h0, 1'b0, 1'b0);
    wait_window(16, 32'h0004_0000, 32'h0004_0000);
    drive(1'b1, 2'd3, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_all("ref setup", 32'hFFFF_0000, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd5);
    chk_all("ref ack", 32'hFFFF_0000, 32'h0, 1'b0, 1'b0);
    wait_window(260, 32'hFFFF_0000, 32'hFFFF_0000);
    idle_check(1, 32'h0, 32'h0);

    // Setup landing on the final count cycle of rank0 bank0.
    drive(1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_all("b0 setup", 32'h1, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk_all("b0 ack", 32'h1, 32'h0, 1'b0, 1'b0);
    idle_check(15, 32'h1, 32'h0);
    drive(1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_all("final-count setup", 32'h0, 32'h1, 1'b1, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_all("re-setup", 32'h1, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk_all("re-ack", 32'h1, 32'h0, 1'b0, 1'b0);
    idle_check(3, 32'h1, 32'h0);

    // Asynchronous reset mid-window while an ackErr pulse is showing.
    drive(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4);
    chk_all("pre-reset bad ack", 32'h1, 32'h0, 1'b0, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk_all("async reset", 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("held reset", 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk_all("post-reset bad ack", 32'h0, 32'h0, 1'b0, 1'b1);
    idle_check(2, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
